// File: rtl/dd2_sub_bridge_pkg.sv
// Shared constants for the Double Dragon 2 sub-CPU bridge: memory-map
// region nibbles (cpu_A[15:12]) and the default shared RAM size.
package dd2_sub_bridge_pkg;

  localparam int AW_DEFAULT = 10;

  localparam logic [3:0] REGION_SHARED = 4'hC;
  localparam logic [3:0] REGION_NMIACK = 4'hD;
  localparam logic [3:0] REGION_IRQMAIN = 4'hE;

  localparam logic [1:0] REGION_HI_IO = 2'b11;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/dd2_shared_dpram.sv
// Generic true dual-port synchronous RAM, both ports on one clock.
// Each port reads the old contents on a write (read-before-write).
// When both ports write the same address in one cycle, port 1 wins.
module dd2_shared_dpram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_data0,
  input  logic          i_we0,
  output logic [DW-1:0] o_q0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_data1,
  input  logic          i_we1,
  output logic [DW-1:0] o_q1
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // Both ports in one block so the port-1 write is ordered after port 0.
  always_ff @(posedge clk) begin
    o_q0 <= r_mem[i_addr0];
    o_q1 <= r_mem[i_addr1];
    if (i_we0) r_mem[i_addr0] <= i_data0;
    if (i_we1) r_mem[i_addr1] <= i_data1;
  end

endmodule

// File: rtl/dd2_sub_bridge.sv
// Glue between the DD2 sound/sub Z80 and the rest of the system:
// memory decode, shared RAM, NMI latch and ROM-wait clock gating.
module dd2_sub_bridge
  import dd2_sub_bridge_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen4,
  input  logic        main_cen,
  input  logic [8:0]  main_AB,
  input  logic        main_wrn,
  input  logic [7:0]  main_dout,
  output logic [7:0]  shared_dout,
  input  logic        com_cs,
  input  logic        mcu_halt,
  input  logic        mcu_nmi_set,
  output logic        mcu_ban,
  output logic        mcu_irqmain,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_busak_n,
  output logic [7:0]  cpu_din,
  output logic        cpu_nmi_n,
  output logic        cpu_busrq_n,
  output logic        cpu_cen,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  logic       w_mreq;
  logic       w_shared_cs;
  logic       w_nmi_ack;
  logic [7:0] w_ram_q0;
  logic [AW-1:0] w_main_addr;

  logic       r_sub_we;
  logic       r_main_we;
  logic [8:0] r_main_a_latch;
  logic       r_com_cs_d;
  logic       r_main_wrn_d;
  logic       r_nmi_set_d;
  logic       r_nmi_arm;
  logic       r_nmi_q;

  assign w_mreq = ~cpu_mreq_n;

  // Sub-CPU memory decode; nothing is selected outside a memory request.
  always_comb begin
    rom_cs      = w_mreq & (cpu_A[15:14] != REGION_HI_IO);
    w_shared_cs = w_mreq & (cpu_A[15:12] == REGION_SHARED);
    w_nmi_ack   = w_mreq & ~cpu_wr_n & (cpu_A[15:12] == REGION_NMIACK);
    mcu_irqmain = w_mreq & ~cpu_wr_n & (cpu_A[15:12] == REGION_IRQMAIN);
  end

  // Read mux toward the Z80; unmapped space reads as open bus.
  always_comb begin
    if (rom_cs)           cpu_din = rom_data;
    else if (w_shared_cs) cpu_din = w_ram_q0;
    else                  cpu_din = OPEN_BUS;
  end

  assign cpu_cen     = cen4 & ~(rom_cs & ~rom_ok);
  assign rom_addr    = cpu_A;
  assign cpu_busrq_n = ~mcu_halt;
  assign mcu_ban     = cpu_busak_n;
  assign cpu_nmi_n   = ~r_nmi_q;

  // NMI latch. r_nmi_arm masks the first sample after reset so a request
  // line held high through reset is not mistaken for a new edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nmi_set_d <= 1'b0;
      r_nmi_arm   <= 1'b0;
      r_nmi_q     <= 1'b0;
    end else begin
      r_nmi_set_d <= mcu_nmi_set;
      r_nmi_arm   <= 1'b1;
      if (w_nmi_ack)
        r_nmi_q <= 1'b0;
      else if (r_nmi_arm && mcu_nmi_set && !r_nmi_set_d)
        r_nmi_q <= 1'b1;
    end
  end

  // Main-side address latch and write strobe; main writes only land
  // while the sub CPU has acknowledged the bus request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_com_cs_d     <= 1'b0;
      r_main_wrn_d   <= 1'b0;
      r_main_a_latch <= '0;
      r_main_we      <= 1'b0;
    end else begin
      r_com_cs_d   <= com_cs;
      r_main_wrn_d <= main_wrn;
      if (com_cs && !r_com_cs_d)
        r_main_a_latch <= main_AB;
      r_main_we <= r_main_wrn_d & ~main_wrn & com_cs & ~cpu_busak_n & main_cen;
    end
  end

  // Sub-side write strobe; the RAM write lands on the following clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sub_we <= 1'b0;
    else       r_sub_we <= ~cpu_wr_n & w_shared_cs & cen4;
  end

  assign w_main_addr = AW'(r_main_a_latch);

  dd2_shared_dpram #(
    .AW (AW),
    .DW (8)
  ) u_ram (
    .clk     (clk),
    .i_addr0 (cpu_A[AW-1:0]),
    .i_data0 (cpu_dout),
    .i_we0   (r_sub_we),
    .o_q0    (w_ram_q0),
    .i_addr1 (w_main_addr),
    .i_data1 (main_dout),
    .i_we1   (r_main_we),
    .o_q1    (shared_dout)
  );

endmodule

// File: tb/tb_dd2_sub_bridge.sv
// Scoreboard bench for dd2_sub_bridge: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dd2_sub_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cen4, main_cen;
  logic [8:0]  main_AB;
  logic        main_wrn;
  logic [7:0]  main_dout;
  logic [7:0]  shared_dout;
  logic        com_cs, mcu_halt, mcu_nmi_set;
  logic        mcu_ban, mcu_irqmain;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n, cpu_wr_n, cpu_busak_n;
  logic [7:0]  cpu_din;
  logic        cpu_nmi_n, cpu_busrq_n, cpu_cen;
  logic [15:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  always #5 clk = ~clk;

  dd2_sub_bridge dut (
    .clk(clk), .rstn(rstn), .cen4(cen4), .main_cen(main_cen),
    .main_AB(main_AB), .main_wrn(main_wrn), .main_dout(main_dout),
    .shared_dout(shared_dout), .com_cs(com_cs), .mcu_halt(mcu_halt),
    .mcu_nmi_set(mcu_nmi_set), .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain),
    .cpu_A(cpu_A), .cpu_dout(cpu_dout), .cpu_mreq_n(cpu_mreq_n),
    .cpu_wr_n(cpu_wr_n), .cpu_busak_n(cpu_busak_n), .cpu_din(cpu_din),
    .cpu_nmi_n(cpu_nmi_n), .cpu_busrq_n(cpu_busrq_n), .cpu_cen(cpu_cen),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  typedef enum int {S_DIN, S_CEN, S_ROMCS, S_NMIN, S_IRQ, S_BUSRQ,
                    S_SDOUT, S_BAN, S_ROMADDR} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] exp;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic logic [15:0] get_sig(sig_e s);
    case (s)
      S_DIN:     return {8'h00, cpu_din};
      S_CEN:     return {15'h0, cpu_cen};
      S_ROMCS:   return {15'h0, rom_cs};
      S_NMIN:    return {15'h0, cpu_nmi_n};
      S_IRQ:     return {15'h0, mcu_irqmain};
      S_BUSRQ:   return {15'h0, cpu_busrq_n};
      S_SDOUT:   return {8'h00, shared_dout};
      S_BAN:     return {15'h0, mcu_ban};
      S_ROMADDR: return rom_addr;
      default:   return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      item_t it;
      logic [15:0] act;
      it  = sb_q.pop_front();
      act = get_sig(it.sig);
      n_checks++;
      if (act !== it.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(string name, sig_e s, logic [15:0] v);
    item_t it;
    it.name = name;
    it.sig  = s;
    it.exp  = v;
    sb_q.push_back(it);
  endtask

  task automatic sub_idle();
    cpu_mreq_n = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic sub_write(logic [15:0] a, logic [7:0] d);
    cpu_A = a; cpu_dout = d; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    cpu_wr_n = 1'b1;
    tick();
  endtask

  task automatic sub_read_expect(string name, logic [15:0] a, logic [7:0] d);
    cpu_A = a; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b1;
    tick();
    expect_sig(name, S_DIN, {8'h00, d});
    tick();
  endtask

  task automatic main_write(logic [8:0] a, logic [7:0] d);
    com_cs = 1'b0; main_wrn = 1'b1;
    tick();
    main_AB = a; com_cs = 1'b1;
    tick();
    main_dout = d; main_wrn = 1'b0;
    tick(2);
    main_wrn = 1'b1; com_cs = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; cen4 = 1'b1; main_cen = 1'b1; main_AB = '0; main_wrn = 1'b1;
    main_dout = '0; com_cs = 1'b0; mcu_halt = 1'b0; mcu_nmi_set = 1'b0;
    cpu_A = '0; cpu_dout = '0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    cpu_busak_n = 1'b1; rom_data = '0; rom_ok = 1'b0;
    tick(3);
    expect_sig("reset_nmi_n", S_NMIN, 16'h1);
    expect_sig("reset_din_idle", S_DIN, 16'h00FF);
    expect_sig("reset_romcs_idle", S_ROMCS, 16'h0);
    expect_sig("reset_busrq_n", S_BUSRQ, 16'h1);
    tick();
    rstn = 1'b1;
    tick(2);

    // ROM fetch with a pending SDRAM access
    cpu_A = 16'h1234; cpu_mreq_n = 1'b0; rom_data = 8'h3E; rom_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_sig("rom_cs_pending", S_ROMCS, 16'h1);
      expect_sig("rom_cen_stall", S_CEN, 16'h0);
      tick();
    end
    rom_ok = 1'b1;
    #1;
    expect_sig("rom_cen_ok", S_CEN, 16'h1);
    expect_sig("rom_din", S_DIN, 16'h003E);
    expect_sig("rom_addr", S_ROMADDR, 16'h1234);
    tick();
    cen4 = 1'b0;
    #1;
    expect_sig("rom_cen4_low", S_CEN, 16'h0);
    tick();
    cen4 = 1'b1;

    // Sub RAM write/read, wrap and open bus
    sub_write(16'hC010, 8'h5A);
    sub_read_expect("sub_rd_c010", 16'hC010, 8'h5A);
    sub_read_expect("sub_rd_wrap_c410", 16'hC410, 8'h5A);
    cpu_A = 16'hF000; cpu_mreq_n = 1'b0;
    #1;
    expect_sig("unmapped_din", S_DIN, 16'h00FF);
    expect_sig("unmapped_romcs", S_ROMCS, 16'h0);
    tick();
    sub_idle();

    // Main write while the sub is halted
    mcu_halt = 1'b1; cpu_busak_n = 1'b0;
    #1;
    expect_sig("busrq_n_halt", S_BUSRQ, 16'h0);
    expect_sig("ban_halted", S_BAN, 16'h0);
    main_write(9'h010, 8'hA5);
    expect_sig("main_rd_010", S_SDOUT, 16'h00A5);
    sub_read_expect("sub_rd_after_main", 16'hC010, 8'hA5);
    sub_idle();

    // Blocked main writes: sub not halted, then main_cen low
    mcu_halt = 1'b0; cpu_busak_n = 1'b1;
    main_write(9'h010, 8'h77);
    expect_sig("main_blocked_busak", S_SDOUT, 16'h00A5);
    cpu_busak_n = 1'b0; main_cen = 1'b0;
    main_write(9'h010, 8'h33);
    expect_sig("main_blocked_cen", S_SDOUT, 16'h00A5);
    main_cen = 1'b1;
    sub_read_expect("sub_rd_unchanged", 16'hC010, 8'hA5);
    sub_idle();

    // Same-address collision: main port wins
    com_cs = 1'b0; tick();
    main_AB = 9'h020; com_cs = 1'b1; tick();
    cpu_A = 16'hC020; cpu_dout = 8'h11; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    main_dout = 8'h22; main_wrn = 1'b0;
    tick();
    cpu_wr_n = 1'b1;
    tick(2);
    expect_sig("collide_sub_view", S_DIN, 16'h0022);
    expect_sig("collide_main_view", S_SDOUT, 16'h0022);
    tick();
    main_wrn = 1'b1; com_cs = 1'b0; cpu_busak_n = 1'b1;
    sub_idle();

    // NMI set, hold, clear, read does not clear, clear beats edge
    mcu_nmi_set = 1'b1; tick();
    expect_sig("nmi_set", S_NMIN, 16'h0);
    mcu_nmi_set = 1'b0; tick(2);
    expect_sig("nmi_hold", S_NMIN, 16'h0);
    cpu_A = 16'hD000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b1; tick();
    expect_sig("nmi_read_no_ack", S_NMIN, 16'h0);
    cpu_wr_n = 1'b0; tick();
    expect_sig("nmi_ack", S_NMIN, 16'h1);
    sub_idle(); tick();
    mcu_nmi_set = 1'b1; cpu_A = 16'hD000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    expect_sig("nmi_ack_beats_edge", S_NMIN, 16'h1);
    sub_idle(); tick(2);
    expect_sig("nmi_level_no_refire", S_NMIN, 16'h1);
    mcu_nmi_set = 1'b0; tick();

    // irqmain is a combinational pulse on writes to 0xExxx
    cpu_A = 16'hE000; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    expect_sig("irq_write", S_IRQ, 16'h1);
    expect_sig("irq_din", S_DIN, 16'h00FF);
    tick();
    cpu_wr_n = 1'b1;
    #1;
    expect_sig("irq_read", S_IRQ, 16'h0);
    tick();
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b0;
    #1;
    expect_sig("irq_no_mreq", S_IRQ, 16'h0);
    tick();
    sub_idle();

    // Async reset mid-operation cancels a pending sub write
    sub_write(16'hC030, 8'h44);
    mcu_nmi_set = 1'b1; tick();
    expect_sig("nmi_before_rst", S_NMIN, 16'h0);
    cpu_A = 16'hC030; cpu_dout = 8'h99; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    rstn = 1'b0; cpu_wr_n = 1'b1;
    #1;
    expect_sig("rst_nmi_immediate", S_NMIN, 16'h1);
    tick(2);
    rstn = 1'b1;
    tick(3);
    expect_sig("nmi_held_through_rst", S_NMIN, 16'h1);
    sub_read_expect("rst_cancels_sub_we", 16'hC030, 8'h44);
    mcu_nmi_set = 1'b0; tick();
    mcu_nmi_set = 1'b1; tick();
    expect_sig("nmi_after_rst_edge", S_NMIN, 16'h0);
    sub_idle();
    tick(2);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
